ifc_cpu: RTL and testbench

Parametrised information-flow-tracking CPU datapath. Every register carries a DATA_W-bit value plus a LABEL_W-bit security level; labels form a total order (0 = public, 2^LABEL_W-1 = top secret) with join = max. Successor of the single-bit high/low core, adding:
- multi-level labels and wider data;
- a working multi-instruction conditional skip;
- implicit-flow tracking through a context label, so branch-dependent writes cannot leak to the public output.

Instructions arrive one per cycle from an external sequencer.

---
 rtl/ifc_cpu.sv | 188 ++++++++++++++++++
 tb/tb_ifc_cpu.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ifc_cpu.sv
// ifc_cpu -- information-flow-tracking CPU datapath.
//
// Every register holds a DATA_W value plus a LABEL_W security level. Labels
// are totally ordered (0 = public, all-ones = top secret) and combine by max.
// A context label tracks implicit flow through SKIP shadows, so writes that
// depend on a secret branch condition are tagged secret.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   instr_valid_i       instruction present this cycle
//   opcode_i            operation
//   dst_i/src1_i/src2_i register indices
//   imm_i               immediate (skip count / classify level)
//   high_i, low_i       secret / public inputs
//   high_o              OUT_HIGH value
//   low_o               OUT_LOW value, forced to 0 when its label is nonzero
//   low_blocked_o       OUT_LOW label nonzero
//   ctx_label_o         current context label
//   shadow_o            skip shadow active
module ifc_cpu #(
   parameter int DATA_W  = 8,
   parameter int LABEL_W = 2,
   parameter int NUM_GPR = 4,
   parameter int IMM_W   = 3,
   parameter int REG_W   = $clog2(5 + NUM_GPR)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               instr_valid_i,
   input  logic [3:0]         opcode_i,
   input  logic [REG_W-1:0]   dst_i,
   input  logic [REG_W-1:0]   src1_i,
   input  logic [REG_W-1:0]   src2_i,
   input  logic [IMM_W-1:0]   imm_i,
   input  logic [DATA_W-1:0]  high_i,
   input  logic [DATA_W-1:0]  low_i,
   output logic [DATA_W-1:0]  high_o,
   output logic [DATA_W-1:0]  low_o,
   output logic               low_blocked_o,
   output logic [LABEL_W-1:0] ctx_label_o,
   output logic               shadow_o
);

   // State slot k holds architectural register k+3 (OUT_HIGH, OUT_LOW, GPRs).
   localparam int NST  = NUM_GPR + 2;
   localparam int MAXL = (2 ** LABEL_W) - 1;

   logic [DATA_W-1:0]  val_q [NST];
   logic [DATA_W-1:0]  val_d [NST];
   logic [LABEL_W-1:0] lab_q [NST];
   logic [LABEL_W-1:0] lab_d [NST];
   logic [IMM_W-1:0]   cnt_q, cnt_d;
   logic [LABEL_W-1:0] ctx_q, ctx_d;
   logic               act_q, act_d;

   logic [DATA_W-1:0]  s1_val, s2_val, res_val;
   logic [LABEL_W-1:0] s1_lab, s2_lab, res_lab, cls_lab;
   logic               wr_en, is_skip, exec;
   logic [IMM_W-1:0]   cnt_dec;

   function automatic logic [LABEL_W-1:0] join_l(input logic [LABEL_W-1:0] a,
                                                  input logic [LABEL_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Operand read: inputs are combinational, unmapped indices read as ZERO.
   always_comb begin
      s1_val = '0;
      s1_lab = '0;
      s2_val = '0;
      s2_lab = '0;
      if (src1_i == REG_W'(1)) begin
         s1_val = high_i;
         s1_lab = '1;
      end else if (src1_i == REG_W'(2)) begin
         s1_val = low_i;
      end
      if (src2_i == REG_W'(1)) begin
         s2_val = high_i;
         s2_lab = '1;
      end else if (src2_i == REG_W'(2)) begin
         s2_val = low_i;
      end
      for (int k = 0; k < NST; k++) begin
         if (int'(src1_i) == k + 3) begin
            s1_val = val_q[k];
            s1_lab = lab_q[k];
         end
         if (int'(src2_i) == k + 3) begin
            s2_val = val_q[k];
            s2_lab = lab_q[k];
         end
      end
   end

   // ALU result and label before the context join.
   always_comb begin
      res_val = '0;
      res_lab = '0;
      wr_en   = 1'b0;
      is_skip = 1'b0;
      cls_lab = (int'(imm_i) > MAXL) ? LABEL_W'(MAXL) : LABEL_W'(imm_i);
      case (opcode_i)
         4'd1: begin res_val = s1_val;          res_lab = s1_lab;                 wr_en = 1'b1; end
         4'd2: begin res_val = ~s1_val;         res_lab = s1_lab;                 wr_en = 1'b1; end
         4'd3: begin res_val = s1_val & s2_val; res_lab = join_l(s1_lab, s2_lab); wr_en = 1'b1; end
         4'd4: begin res_val = s1_val | s2_val; res_lab = join_l(s1_lab, s2_lab); wr_en = 1'b1; end
         4'd5: begin res_val = s1_val ^ s2_val; res_lab = join_l(s1_lab, s2_lab); wr_en = 1'b1; end
         4'd6: begin res_val = s1_val + s2_val; res_lab = join_l(s1_lab, s2_lab); wr_en = 1'b1; end
         4'd7: begin res_val = s1_val;          res_lab = join_l(s1_lab, cls_lab); wr_en = 1'b1; end
         4'd8: begin res_val = DATA_W'(s1_lab); res_lab = '0;                     wr_en = 1'b1; end
         4'd9: is_skip = 1'b1;
         default: ;
      endcase
   end

   // Next state: register writes and shadow bookkeeping.
   always_comb begin
      val_d   = val_q;
      lab_d   = lab_q;
      cnt_d   = cnt_q;
      ctx_d   = ctx_q;
      act_d   = act_q;
      cnt_dec = cnt_q - IMM_W'(1);
      // Inside an active (taken) shadow the instruction still costs a cycle
      // but behaves as NOP.
      exec    = instr_valid_i && !((cnt_q != '0) && act_q);

      if (exec && wr_en) begin
         for (int k = 0; k < NST; k++) begin
            if (int'(dst_i) == k + 3) begin
               val_d[k] = res_val;
               lab_d[k] = join_l(res_lab, ctx_q);
            end
         end
      end

      if (instr_valid_i) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_dec;
            if (exec && is_skip) begin
               // Nested skip: window can only extend; the condition takes
               // over only if the new window covers the rest of the old one.
               if (imm_i > cnt_dec) cnt_d = imm_i;
               if (imm_i >= cnt_dec) act_d = (s1_val != '0);
               ctx_d = join_l(ctx_q, s1_lab);
            end
         end else if (is_skip) begin
            // The window opens regardless of the condition, so its length
            // never reveals the condition.
            cnt_d = imm_i;
            act_d = (s1_val != '0);
            ctx_d = join_l(ctx_q, s1_lab);
         end
         if (cnt_d == '0) begin
            ctx_d = '0;
            act_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NST; k++) begin
            val_q[k] <= '0;
            lab_q[k] <= '0;
         end
         cnt_q <= '0;
         ctx_q <= '0;
         act_q <= 1'b0;
      end else begin
         for (int k = 0; k < NST; k++) begin
            val_q[k] <= val_d[k];
            lab_q[k] <= lab_d[k];
         end
         cnt_q <= cnt_d;
         ctx_q <= ctx_d;
         act_q <= act_d;
      end
   end

   assign high_o        = val_q[0];
   assign low_blocked_o = (lab_q[1] != '0);
   assign low_o         = low_blocked_o ? '0 : val_q[1];
   assign ctx_label_o   = ctx_q;
   assign shadow_o      = (cnt_q != '0);

endmodule

// File: tb/tb_ifc_cpu.sv
module tb_ifc_cpu;

   logic       clk = 1'b0;
   logic       reset;
   logic       instr_valid_i;
   logic [3:0] opcode_i;
   logic [3:0] dst_i, src1_i, src2_i;
   logic [2:0] imm_i;
   logic [7:0] high_i, low_i;
   logic [7:0] high_o, low_o;
   logic       low_blocked_o;
   logic [1:0] ctx_label_o;
   logic       shadow_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ifc_cpu dut (
      .clk(clk), .reset(reset), .instr_valid_i(instr_valid_i), .opcode_i(opcode_i),
      .dst_i(dst_i), .src1_i(src1_i), .src2_i(src2_i), .imm_i(imm_i),
      .high_i(high_i), .low_i(low_i), .high_o(high_o), .low_o(low_o),
      .low_blocked_o(low_blocked_o), .ctx_label_o(ctx_label_o), .shadow_o(shadow_o)
   );

   // Reference model: register file indexed by architectural register number.
   int mv[16];
   int ml[16];
   int rem;        // valid instructions left in the shadow
   bit supp;       // shadow suppresses its instructions
   int ctx;

   function automatic int imax(int a, int b);
      return (a > b) ? a : b;
   endfunction

   task automatic model_read(input int r, input int hi, input int lo, output int v, output int l);
      v = 0; l = 0;
      if (r == 1) begin v = hi; l = 3; end
      else if (r == 2) begin v = lo; l = 0; end
      else if (r >= 3 && r <= 8) begin v = mv[r]; l = ml[r]; end
   endtask

   task automatic model_step(input bit rst, input bit v, input int op, input int d,
                             input int s1, input int s2, input int imm, input int hi, input int lo);
      int a, la, b, lb, rv, rl;
      bit wr, in_sh;
      if (rst) begin
         for (int i = 0; i < 16; i++) begin mv[i] = 0; ml[i] = 0; end
         rem = 0; supp = 0; ctx = 0;
         return;
      end
      if (!v) return;
      in_sh = (rem > 0);
      if (in_sh && supp) begin
         rem = rem - 1;
      end else begin
         model_read(s1, hi, lo, a, la);
         model_read(s2, hi, lo, b, lb);
         wr = 1; rv = 0; rl = imax(la, lb);
         case (op)
            1: begin rv = a; rl = la; end
            2: begin rv = 255 - a; rl = la; end
            3: rv = a & b;
            4: rv = a | b;
            5: rv = a ^ b;
            6: rv = (a + b) % 256;
            7: begin rv = a; rl = imax(la, (imm > 3) ? 3 : imm); end
            8: begin rv = la; rl = 0; end
            default: wr = 0;
         endcase
         if (wr && d >= 3 && d <= 8) begin
            mv[d] = rv;
            ml[d] = imax(rl, ctx);
         end
         if (op == 9) begin
            if (in_sh) begin
               if (imm >= rem - 1) supp = (a != 0);
               rem = imax(rem - 1, imm);
            end else begin
               rem = imm;
               supp = (a != 0);
            end
            ctx = imax(ctx, la);
         end else if (in_sh) begin
            rem = rem - 1;
         end
      end
      if (rem == 0) begin ctx = 0; supp = 0; end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle, advance the model, then sample #1 after the edge.
   task automatic cyc(input bit rst, input bit v, input int op, input int d, input int s1,
                      input int s2, input int imm, input int hi, input int lo);
      reset = rst; instr_valid_i = v;
      opcode_i = op[3:0]; dst_i = d[3:0]; src1_i = s1[3:0]; src2_i = s2[3:0];
      imm_i = imm[2:0]; high_i = hi[7:0]; low_i = lo[7:0];
      model_step(rst, v, op, d, s1, s2, imm, hi, lo);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".high_o"}, int'(high_o), mv[3]);
      chk({tag, ".low_o"}, int'(low_o), (ml[4] == 0) ? mv[4] : 0);
      chk({tag, ".low_blocked_o"}, int'(low_blocked_o), int'(ml[4] != 0));
      chk({tag, ".ctx_label_o"}, int'(ctx_label_o), ctx);
      chk({tag, ".shadow_o"}, int'(shadow_o), int'(rem > 0));
   endtask

   typedef struct {
      int op, d, s1, s2, imm, hi, lo;
      int e_high, e_low, e_blk, e_ctx, e_sh;
   } vec_t;

   vec_t tbl[20];

   initial begin
      //           op d  s1 s2 imm hi    lo      high  low   blk ctx sh
      tbl[0]  = '{1, 4, 2, 0, 0, 'h00, 'h5A, 'h00, 'h5A, 0, 0, 0};
      tbl[1]  = '{1, 4, 1, 0, 0, 'h33, 'h00, 'h00, 'h00, 1, 0, 0};
      tbl[2]  = '{8, 5, 4, 0, 0, 'h00, 'h00, 'h00, 'h00, 1, 0, 0};
      tbl[3]  = '{1, 3, 5, 0, 0, 'h00, 'h00, 'h03, 'h00, 1, 0, 0};
      tbl[4]  = '{1, 4, 0, 0, 0, 'h00, 'h00, 'h03, 'h00, 0, 0, 0};
      tbl[5]  = '{9, 0, 1, 0, 1, 'h01, 'h00, 'h03, 'h00, 0, 3, 1};
      tbl[6]  = '{2, 4, 0, 0, 0, 'h01, 'h00, 'h03, 'h00, 0, 0, 0};
      tbl[7]  = '{1, 4, 0, 0, 0, 'h01, 'h00, 'h03, 'h00, 0, 0, 0};
      tbl[8]  = '{9, 0, 1, 0, 1, 'h00, 'h00, 'h03, 'h00, 0, 3, 1};
      tbl[9]  = '{2, 4, 0, 0, 0, 'h00, 'h00, 'h03, 'h00, 1, 0, 0};
      tbl[10] = '{1, 4, 0, 0, 0, 'h00, 'h00, 'h03, 'h00, 0, 0, 0};
      tbl[11] = '{7, 5, 2, 0, 1, 'h00, 'hFF, 'h03, 'h00, 0, 0, 0};
      tbl[12] = '{7, 6, 2, 0, 2, 'h00, 'h02, 'h03, 'h00, 0, 0, 0};
      tbl[13] = '{6, 3, 5, 6, 0, 'h00, 'h00, 'h01, 'h00, 0, 0, 0};
      tbl[14] = '{8, 7, 3, 0, 0, 'h00, 'h00, 'h01, 'h00, 0, 0, 0};
      tbl[15] = '{1, 3, 7, 0, 0, 'h00, 'h00, 'h02, 'h00, 0, 0, 0};
      tbl[16] = '{7, 3, 0, 0, 7, 'h00, 'h00, 'h00, 'h00, 0, 0, 0};
      tbl[17] = '{8, 3, 3, 0, 0, 'h00, 'h00, 'h03, 'h00, 0, 0, 0};
      tbl[18] = '{1, 1, 2, 0, 0, 'h00, 'h77, 'h03, 'h00, 0, 0, 0};
      tbl[19] = '{1, 3, 12, 0, 0, 'h9A, 'h77, 'h00, 'h00, 0, 0, 0};

      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("reset.high_o", int'(high_o), 0);
      chk("reset.low_o", int'(low_o), 0);
      chk("reset.low_blocked_o", int'(low_blocked_o), 0);
      chk("reset.ctx_label_o", int'(ctx_label_o), 0);
      chk("reset.shadow_o", int'(shadow_o), 0);

      for (int i = 0; i < 20; i++) begin
         cyc(0, 1, tbl[i].op, tbl[i].d, tbl[i].s1, tbl[i].s2, tbl[i].imm, tbl[i].hi, tbl[i].lo);
         chk($sformatf("vec%0d.high_o", i), int'(high_o), tbl[i].e_high);
         chk($sformatf("vec%0d.low_o", i), int'(low_o), tbl[i].e_low);
         chk($sformatf("vec%0d.blocked", i), int'(low_blocked_o), tbl[i].e_blk);
         chk($sformatf("vec%0d.ctx", i), int'(ctx_label_o), tbl[i].e_ctx);
         chk($sformatf("vec%0d.shadow", i), int'(shadow_o), tbl[i].e_sh);
      end

      // Shadow with gaps: 3 valid instructions suppressed, idle cycles ignored.
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 9, 0, 2, 0, 3, 0, 5);
      chk("gap.sh_open", int'(shadow_o), 1);
      cyc(0, 1, 1, 4, 2, 0, 0, 0, 5);
      chk("gap.sh1", int'(shadow_o), 1);
      chk("gap.low1", int'(low_o), 0);
      cyc(0, 0, 1, 4, 2, 0, 0, 0, 5);
      cyc(0, 0, 1, 4, 2, 0, 0, 0, 5);
      chk("gap.sh_idle", int'(shadow_o), 1);
      chk("gap.low_idle", int'(low_o), 0);
      cyc(0, 1, 1, 4, 2, 0, 0, 0, 5);
      chk("gap.sh2", int'(shadow_o), 1);
      cyc(0, 1, 1, 4, 2, 0, 0, 0, 5);
      chk("gap.sh3", int'(shadow_o), 0);
      chk("gap.low3", int'(low_o), 0);
      cyc(0, 1, 1, 4, 2, 0, 0, 0, 5);
      chk("gap.low_after", int'(low_o), 5);

      // Reset mid-shadow with a valid instruction present.
      cyc(0, 1, 9, 0, 1, 0, 3, 1, 0);
      cyc(0, 1, 1, 4, 2, 0, 0, 1, 'h11);
      chk("rstmid.sh_before", int'(shadow_o), 1);
      chk("rstmid.ctx_before", int'(ctx_label_o), 3);
      cyc(1, 1, 1, 4, 2, 0, 0, 1, 'h22);
      chk("rstmid.sh", int'(shadow_o), 0);
      chk("rstmid.ctx", int'(ctx_label_o), 0);
      chk("rstmid.low", int'(low_o), 0);
      cyc(0, 1, 1, 4, 2, 0, 0, 1, 'h3C);
      chk("rstmid.next", int'(low_o), 'h3C);

      // Randomized run against the reference model.
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 600; n++) begin
         int op;
         op = ($urandom_range(0, 3) == 0) ? 9 : int'($urandom_range(0, 15));
         cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8), op,
             int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
             int'($urandom_range(0, 10)), int'($urandom_range(0, 7)),
             ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 255)),
             ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 255)));
         chk_model($sformatf("rnd%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
